// File: rtl/bit_scan_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : bit_scan_encoder
//  Purpose  : Accepts a WIDTH-bit request vector and emits the binary index
//             of every set bit, lowest index first, one index per output
//             handshake. Flags the final beat and reports all-zero vectors
//             as a single "empty" beat. Popcount is held for the frame.
//  Revision : 1.0  initial release
// ============================================================================
module bit_scan_encoder #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              out_empty,
    output logic [CODE_W:0]   out_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [CODE_W:0]    cnt_q, cnt_d;
    logic               empty_q, empty_d;

    logic [CODE_W-1:0]  w_low_idx;
    logic [CODE_W:0]    w_popcnt;
    logic [WIDTH-1:0]   w_pending_clr;
    logic               w_single;
    logic               w_emit;
    logic               w_last;
    logic               w_out_hs;
    logic               w_in_hs;

    // Lowest set bit of the pending vector; scanning downward lets the
    // lowest index overwrite higher ones. Zero vector yields index 0.
    always_comb begin
        w_low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                w_low_idx = CODE_W'(i);
            end
        end
    end

    // Popcount of the incoming vector, captured at accept time.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + {{CODE_W{1'b0}}, in_data[i]};
        end
    end

    // Registered-only output decode; a frame is on its last beat when at
    // most one bit remains (or it was the empty report).
    always_comb begin
        w_pending_clr = pending_q & (pending_q - WIDTH'(1));
        w_single      = (w_pending_clr == '0);
        w_emit        = (state_q == ST_EMIT);
        w_last        = w_emit && (empty_q || w_single);

        out_valid = w_emit;
        out_code  = w_emit ? w_low_idx : '0;
        out_last  = w_last;
        out_empty = w_emit && empty_q;
        out_cnt   = w_emit ? cnt_q : '0;

        // Only combinational input-to-output path: out_ready -> in_ready.
        in_ready  = (state_q == ST_IDLE) || (w_emit && out_ready && w_last);

        w_out_hs  = w_emit && out_ready;
        w_in_hs   = in_valid && in_ready;
    end

    // Next-state: retire the lowest bit per beat, finish the frame on the
    // last beat, and load a new vector whenever one is accepted (which may
    // coincide with the last beat for bubble-free back-to-back frames).
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        empty_d   = empty_q;

        if (w_out_hs) begin
            if (!w_last) begin
                pending_d = w_pending_clr;
            end else begin
                state_d   = ST_IDLE;
                pending_d = '0;
                cnt_d     = '0;
                empty_d   = 1'b0;
            end
        end

        if (w_in_hs) begin
            state_d   = ST_EMIT;
            pending_d = in_data;
            cnt_d     = w_popcnt;
            empty_d   = (in_data == '0);
        end
    end

    // State and frame registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            empty_q   <= empty_d;
        end
    end

endmodule
`default_nettype wire
